// File: rtl/max_pool2d_pkg.sv
//------------------------------------------------------------------------------
// Module  : max_pool2d_pkg
// Brief   : Shared defaults and FSM state encoding for the 2-D max-pool engine.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package max_pool2d_pkg;

  localparam int MP_IN_W  = 111;
  localparam int MP_OUT_W = 55;
  localparam int MP_K     = 3;
  localparam int MP_S     = 2;
  localparam int MP_CH    = 64;
  localparam int MP_DW    = 16;
  localparam int MP_AW    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/max_pool2d_cmp.sv
//------------------------------------------------------------------------------
// Module  : max_pool2d_cmp
// Brief   : CH-lane combinational signed maximum. With load high the new tap is
//           passed straight through so a window never inherits an old maximum.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module max_pool2d_cmp
  import max_pool2d_pkg::*;
#(
  parameter int CH = MP_CH,
  parameter int DW = MP_DW
) (
  input  logic             load,
  input  logic [CH*DW-1:0] acc,
  input  logic [CH*DW-1:0] din,
  output logic [CH*DW-1:0] max_o
);

  for (genvar n = 0; n < CH; n++) begin : g_lane
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    assign a = acc[n*DW +: DW];
    assign b = din[n*DW +: DW];
    assign max_o[n*DW +: DW] = (load || (b > a)) ? b : a;
  end

endmodule

`default_nettype wire

// File: rtl/max_pool2d.sv
//------------------------------------------------------------------------------
// Module  : max_pool2d
// Brief   : KxK / stride-S max pooling over a square CH-lane feature map held
//           in an external bank with one-cycle read latency. One tap address
//           is issued per cycle; one pooled pixel is strobed per window.
//           Build option: define MAXPOOL_RELU_EN to clamp negative lane
//           results to zero before they are registered.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module max_pool2d
  import max_pool2d_pkg::*;
#(
  parameter int IN_W  = MP_IN_W,
  parameter int OUT_W = MP_OUT_W,
  parameter int K     = MP_K,
  parameter int S     = MP_S,
  parameter int CH    = MP_CH,
  parameter int DW    = MP_DW,
  parameter int AW    = MP_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_data_valid,
  output logic [AW-1:0]    pooladdr,
  input  logic [CH*DW-1:0] inp,
  output logic [CH*DW-1:0] maxpoolout,
  output logic             maxpoolvalid
);

  localparam int CW = $clog2(((OUT_W > K) ? OUT_W : K) + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     orow_q, orow_d, ocol_q, ocol_d, kr_q, kr_d, kc_q, kc_d;
  logic              iss_q, iss_d;
  logic              tap_vld_q, tap_vld_d, tap_first_q, tap_first_d;
  logic              tap_last_q, tap_last_d, frm_last_q, frm_last_d;
  logic [CH*DW-1:0]  run_max_q, run_max_d;
  logic [AW-1:0]     pooladdr_q, pooladdr_d;
  logic [CH*DW-1:0]  maxpoolout_q, maxpoolout_d;
  logic              maxpoolvalid_q, maxpoolvalid_d;

  logic [CW-1:0]     nkr, nkc, nocol, norow;
  logic [AW-1:0]     next_addr;
  logic              first0, last0, flast0;
  logic [CH*DW-1:0]  cmp_max, lane_res;

  max_pool2d_cmp #(.CH(CH), .DW(DW)) u_cmp (
    .load  (tap_first_q),
    .acc   (run_max_q),
    .din   (inp),
    .max_o (cmp_max)
  );

`ifdef MAXPOOL_RELU_EN
  for (genvar n = 0; n < CH; n++) begin : g_relu
    assign lane_res[n*DW +: DW] = cmp_max[n*DW + DW - 1] ? '0 : cmp_max[n*DW +: DW];
  end
`else
  assign lane_res = cmp_max;
`endif

  // Position of the tap currently on the address bus, and the tap after it.
  always_comb begin
    first0 = iss_q && (kr_q == '0) && (kc_q == '0);
    last0  = iss_q && (kr_q == CW'(K - 1)) && (kc_q == CW'(K - 1));
    flast0 = last0 && (orow_q == CW'(OUT_W - 1)) && (ocol_q == CW'(OUT_W - 1));
    nkc    = kc_q + CW'(1);
    nkr    = kr_q;
    nocol  = ocol_q;
    norow  = orow_q;
    if (kc_q == CW'(K - 1)) begin
      nkc = '0;
      nkr = kr_q + CW'(1);
      if (kr_q == CW'(K - 1)) begin
        nkr   = '0;
        nocol = ocol_q + CW'(1);
        if (ocol_q == CW'(OUT_W - 1)) begin
          nocol = '0;
          norow = orow_q + CW'(1);
        end
      end
    end
    next_addr = (AW'(S) * AW'(norow) + AW'(nkr)) * AW'(IN_W)
              + AW'(S) * AW'(nocol) + AW'(nkc);
  end

  // Frame sequencing: address issue, one-cycle-late tap capture, strobe.
  always_comb begin
    state_d        = state_q;
    orow_d         = orow_q;
    ocol_d         = ocol_q;
    kr_d           = kr_q;
    kc_d           = kc_q;
    iss_d          = iss_q;
    tap_vld_d      = 1'b0;
    tap_first_d    = 1'b0;
    tap_last_d     = 1'b0;
    frm_last_d     = 1'b0;
    run_max_d      = run_max_q;
    pooladdr_d     = pooladdr_q;
    maxpoolout_d   = maxpoolout_q;
    maxpoolvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        orow_d     = '0;
        ocol_d     = '0;
        kr_d       = '0;
        kc_d       = '0;
        pooladdr_d = '0;
        iss_d      = 1'b0;
        if (i_data_valid) begin
          state_d = RUN;
          iss_d   = 1'b1;
        end
      end
      RUN: begin
        if (!i_data_valid) begin
          // Abort: drop all progress, including any window about to complete.
          state_d    = IDLE;
          orow_d     = '0;
          ocol_d     = '0;
          kr_d       = '0;
          kc_d       = '0;
          iss_d      = 1'b0;
          pooladdr_d = '0;
        end else begin
          tap_vld_d   = iss_q;
          tap_first_d = first0;
          tap_last_d  = last0;
          frm_last_d  = flast0;
          if (iss_q) begin
            if (flast0) begin
              iss_d = 1'b0;
            end else begin
              orow_d     = norow;
              ocol_d     = nocol;
              kr_d       = nkr;
              kc_d       = nkc;
              pooladdr_d = next_addr;
            end
          end
          if (tap_vld_q) begin
            run_max_d = cmp_max;
            if (tap_last_q) begin
              maxpoolout_d   = lane_res;
              maxpoolvalid_d = 1'b1;
              if (frm_last_q) begin
                state_d = DONE;
              end
            end
          end
        end
      end
      DONE: begin
        if (!i_data_valid) begin
          state_d    = IDLE;
          orow_d     = '0;
          ocol_d     = '0;
          kr_d       = '0;
          kc_d       = '0;
          pooladdr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset acts immediately, independent of clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      orow_q         <= '0;
      ocol_q         <= '0;
      kr_q           <= '0;
      kc_q           <= '0;
      iss_q          <= 1'b0;
      tap_vld_q      <= 1'b0;
      tap_first_q    <= 1'b0;
      tap_last_q     <= 1'b0;
      frm_last_q     <= 1'b0;
      run_max_q      <= '0;
      pooladdr_q     <= '0;
      maxpoolout_q   <= '0;
      maxpoolvalid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      orow_q         <= orow_d;
      ocol_q         <= ocol_d;
      kr_q           <= kr_d;
      kc_q           <= kc_d;
      iss_q          <= iss_d;
      tap_vld_q      <= tap_vld_d;
      tap_first_q    <= tap_first_d;
      tap_last_q     <= tap_last_d;
      frm_last_q     <= frm_last_d;
      run_max_q      <= run_max_d;
      pooladdr_q     <= pooladdr_d;
      maxpoolout_q   <= maxpoolout_d;
      maxpoolvalid_q <= maxpoolvalid_d;
    end
  end

  assign pooladdr     = pooladdr_q;
  assign maxpoolout   = maxpoolout_q;
  assign maxpoolvalid = maxpoolvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_max_pool2d.sv
//------------------------------------------------------------------------------
// Module  : tb_max_pool2d
// Brief   : Self-checking bench for max_pool2d with a one-cycle-latency bank
//           model and a scoreboard of expected pooled pixels.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_max_pool2d;

  localparam int IN_W  = 111;
  localparam int OUT_W = 55;
  localparam int K     = 3;
  localparam int S     = 2;
  localparam int CH    = 64;
  localparam int DW    = 16;
  localparam int AW    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_data_valid;
  logic [AW-1:0]    pooladdr;
  logic [CH*DW-1:0] inp;
  logic [CH*DW-1:0] maxpoolout;
  logic             maxpoolvalid;

  max_pool2d #(
    .IN_W(IN_W), .OUT_W(OUT_W), .K(K), .S(S), .CH(CH), .DW(DW), .AW(AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_data_valid (i_data_valid),
    .pooladdr     (pooladdr),
    .inp          (inp),
    .maxpoolout   (maxpoolout),
    .maxpoolvalid (maxpoolvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] l0;
    logic [DW-1:0] l1;
    logic [DW-1:0] lz;
  } exp_t;

  typedef struct {
    logic [8:0][DW-1:0] taps;
    logic [DW-1:0]      raw;
    logic [DW-1:0]      relu;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   strobes  = 0;
  int   frame_id = 0;
  int   seen_id  = 0;
  int   prev_n   = 0;

  // Cycle index since frame start: during the k-th RUN cycle (k from 0), n = k+1.
  int n;
  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= i_data_valid ? n + 1 : 0;
  end

  // Bank model: one-cycle read latency, every lane returns its own address.
  logic [AW-1:0]      mem_addr_q;
  logic               tbl_mode;
  logic [8:0][DW-1:0] cur_taps;
  int                 tap_i;
  always @(posedge clk) mem_addr_q <= pooladdr;

  always_comb begin
    inp   = '0;
    tap_i = n - 2;
    for (int l = 0; l < CH; l++) inp[l*DW +: DW] = mem_addr_q[DW-1:0];
    if (tbl_mode && tap_i >= 0) inp[DW-1:0] = (tap_i < 9) ? cur_taps[tap_i] : 16'h0001;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int v0, input int v1, input int vz);
    exp_t e;
    e.l0 = DW'(v0);
    e.l1 = DW'(v1);
    e.lz = DW'(vz);
    sb_q.push_back(e);
  endtask

  function automatic int win_max_addr(input int r, input int c);
    return (S*r + K - 1)*IN_W + S*c + K - 1;
  endfunction

  function automatic logic [8:0][DW-1:0] mk(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8);
    logic [8:0][DW-1:0] r;
    r[0] = DW'(a0); r[1] = DW'(a1); r[2] = DW'(a2);
    r[3] = DW'(a3); r[4] = DW'(a4); r[5] = DW'(a5);
    r[6] = DW'(a6); r[7] = DW'(a7); r[8] = DW'(a8);
    return r;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic wait_n(input string name, input int target);
    int c;
    c = 0;
    while (n < target && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(name, n, target);
  endtask

  // Scoreboard monitor: pop and compare on every strobe, check strobe timing.
  always @(negedge clk) begin
    if (maxpoolvalid) begin
      strobes++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got strobe at n=%0d expected none", n);
      end else begin
        mon_e = sb_q.pop_front();
        chk("lane0", maxpoolout[DW-1:0], mon_e.l0);
        chk("lane1", maxpoolout[2*DW-1:DW], mon_e.l1);
        chk("lane_last", maxpoolout[CH*DW-1 -: DW], mon_e.lz);
        if (seen_id != frame_id) chk("first_latency", n - 1, 10);
        else                     chk("strobe_spacing", n - prev_n, K*K);
        seen_id = frame_id;
        prev_n  = n;
      end
    end
  end

  vec_t tbl[7];
  int   addr_exp[9];
  int   s0;

  initial begin
    rst          = 1'b0;
    i_data_valid = 1'b0;
    tbl_mode     = 1'b0;
    cur_taps     = '0;

    tbl[0].taps = mk(-5, -1, -7, -3, -9, -2, -4, -8, -6);
    tbl[0].raw  = 16'hFFFF;  tbl[0].relu = 16'h0000;
    tbl[1].taps = mk(-32768, -32768, -32768, -32768, 32767, -32768, -32768, -32768, -32768);
    tbl[1].raw  = 16'h7FFF;  tbl[1].relu = 16'h7FFF;
    tbl[2].taps = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    tbl[2].raw  = 16'h8000;  tbl[2].relu = 16'h0000;
    tbl[3].taps = mk(3, -2, 10, 0, -1, 9, 10, 4, -32768);
    tbl[3].raw  = 16'h000A;  tbl[3].relu = 16'h000A;
    tbl[4].taps = mk(100, 1, 2, 3, 4, 5, 6, 7, 8);
    tbl[4].raw  = 16'h0064;  tbl[4].relu = 16'h0064;
    tbl[5].taps = mk(1, 2, 3, 4, 5, 6, 7, 8, 4660);
    tbl[5].raw  = 16'h1234;  tbl[5].relu = 16'h1234;
    tbl[6].taps = mk(0, -1, -2, -3, -4, -5, -6, -7, -8);
    tbl[6].raw  = 16'h0000;  tbl[6].relu = 16'h0000;

    addr_exp = '{0, 1, 2, 111, 112, 113, 222, 223, 224};

    // Reset state
    #12;
    chk("reset_pooladdr", pooladdr, 0);
    chk("reset_maxpoolout", maxpoolout, 0);
    chk("reset_maxpoolvalid", maxpoolvalid, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors: lane 0 window 0 from the table, window 1 all 0x0001.
    tbl_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cur_taps = tbl[i].taps;
`ifdef MAXPOOL_RELU_EN
      push_exp(int'(tbl[i].relu), 224, 224);
`else
      push_exp(int'(tbl[i].raw), 224, 224);
`endif
      push_exp(1, 226, 226);
      frame_id++;
      i_data_valid = 1'b1;
      wait_drain("vector_drain", 40);
      i_data_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    tbl_mode = 1'b0;

    // Abort at cycle 40: four windows complete, nothing afterwards.
    for (int c = 0; c < 4; c++) push_exp(win_max_addr(0, c), win_max_addr(0, c), win_max_addr(0, c));
    frame_id++;
    i_data_valid = 1'b1;
    wait_n("abort_reach_cycle40", 41);
    i_data_valid = 1'b0;
    s0 = strobes;
    repeat (30) @(negedge clk);
    chk("abort_no_strobe", strobes - s0, 0);
    chk("abort_queue_empty", sb_q.size(), 0);
    chk("abort_idle_addr", pooladdr, 0);
    sb_q.delete();

    // Restart: first window address order, then async reset mid-strobe.
    push_exp(224, 224, 224);
    push_exp(226, 226, 226);
    frame_id++;
    i_data_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("restart_addr", pooladdr, addr_exp[i]);
    end
    wait_n("reach_second_strobe", 20);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_pooladdr", pooladdr, 0);
    chk("async_rst_maxpoolout", maxpoolout, 0);
    chk("async_rst_maxpoolvalid", maxpoolvalid, 0);
    chk("pre_reset_queue_empty", sb_q.size(), 0);
    sb_q.delete();

    // Full frame after reset release, restarting at pixel (0,0).
    for (int r = 0; r < OUT_W; r++)
      for (int c = 0; c < OUT_W; c++)
        push_exp(win_max_addr(r, c), win_max_addr(r, c), win_max_addr(r, c));
    frame_id++;
    @(negedge clk);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("post_reset_addr", pooladdr, addr_exp[i]);
    end
    s0 = strobes;
    wait_drain("frame_drain", 30000);
    chk("frame_strobes", strobes - s0, OUT_W*OUT_W + 0);
    chk("done_last_addr", pooladdr, IN_W*IN_W - 1);
    s0 = strobes;
    repeat (20) @(negedge clk);
    chk("done_no_strobe", strobes - s0, 0);
    chk("done_hold_addr", pooladdr, IN_W*IN_W - 1);
    i_data_valid = 1'b0;
    @(negedge clk);
    chk("idle_addr_zero", pooladdr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
